spi_master_shift: RTL

- Parametrised full-duplex SPI master shift engine. It is the next generation of the 8-bit byte shifter.
- Generates sck, cs_n and mosi from a programmable clock divider and captures miso into a WIDTH-bit receive word.
- Supports all four CPOL/CPHA modes and either bit order.
- Sits between the register/bus layer (start/busy/done handshake) and the external SPI pins.

---
 rtl/spi_master_shift_if.sv | 40 ++++
 rtl/spi_master_shift.sv | 122 ++++++++++++
 2 files changed

// File: rtl/spi_master_shift_if.sv
// Bus-side handshake and SPI pin bundle for spi_master_shift.
// The loopback signal exists only when SPI_MASTER_LOOPBACK_EN is defined.
interface spi_master_shift_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 8
);
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic [DIV_W-1:0] div;
  logic             cpol;
  logic             cpha;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;
  logic             sck;
  logic             cs_n;
  logic             mosi;
  logic             miso;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic             loopback;

  modport master (
    output start, tx_data, div, cpol, cpha, miso, loopback,
    input  busy, done, rx_data, sck, cs_n, mosi
  );
  modport slave (
    input  start, tx_data, div, cpol, cpha, miso, loopback,
    output busy, done, rx_data, sck, cs_n, mosi
  );
`else
  modport master (
    output start, tx_data, div, cpol, cpha, miso,
    input  busy, done, rx_data, sck, cs_n, mosi
  );
  modport slave (
    input  start, tx_data, div, cpol, cpha, miso,
    output busy, done, rx_data, sck, cs_n, mosi
  );
`endif
endinterface

// File: rtl/spi_master_shift.sv
// Full-duplex SPI master shift engine, all CPOL/CPHA modes, selectable bit order.
// Optional internal mosi->sampler loopback enabled by SPI_MASTER_LOOPBACK_EN.
module spi_master_shift #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_W     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input logic              clk,
  input logic              rst,
  spi_master_shift_if.slave bus
);
  localparam int unsigned EW = $clog2(2*WIDTH+1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t           r_state, w_next;
  logic [DIV_W-1:0] r_cnt, r_div;
  logic [EW-1:0]    r_edge;
  logic [WIDTH-1:0] r_tx, r_rx, r_rx_data;
  logic             r_cpha, r_sck, r_done;
  logic             w_hp_end, w_accept, w_edge, w_lead, w_last;
  logic             w_sample, w_shift, w_sin;
  logic             w_busy, w_cs_n, w_mosi;

  assign w_hp_end = (r_cnt == '0);
  assign w_accept = (r_state == IDLE) && bus.start && !r_done;
  assign w_edge   = (r_state == XFER) && w_hp_end;
  // r_edge holds completed edges, so an even count means the next edge is leading
  assign w_lead   = ~r_edge[0];
  assign w_last   = (r_edge == EW'(2*WIDTH-1));
  assign w_sample = w_edge && (w_lead ^ r_cpha);
  assign w_shift  = w_edge && !(w_lead ^ r_cpha) && !(r_cpha ? (r_edge == '0) : w_last);

`ifdef SPI_MASTER_LOOPBACK_EN
  logic r_lb;
  always_ff @(posedge clk) begin
    if (rst)           r_lb <= 1'b0;
    else if (w_accept) r_lb <= bus.loopback;
  end
  assign w_sin = r_lb ? w_mosi : bus.miso;
`else
  assign w_sin = bus.miso;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_next = LEAD;
      LEAD:  if (w_hp_end) w_next = XFER;
      XFER:  if (w_edge && w_last) w_next = TRAIL;
      TRAIL: if (w_hp_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_cs_n = 1'b1;
    w_mosi = 1'b0;
    case (r_state)
      LEAD, XFER, TRAIL: begin
        w_busy = 1'b1;
        w_cs_n = 1'b0;
        w_mosi = LSB_FIRST ? r_tx[0] : r_tx[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_div     <= '0;
      r_edge    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_cpha    <= 1'b0;
      r_sck     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        r_sck <= bus.cpol;
        if (w_accept) begin
          r_cnt  <= bus.div;
          r_div  <= bus.div;
          r_tx   <= bus.tx_data;
          r_cpha <= bus.cpha;
          r_edge <= '0;
          r_rx   <= '0;
        end
      end else begin
        r_cnt <= w_hp_end ? r_div : r_cnt - DIV_W'(1);
        if (w_edge) begin
          r_sck  <= ~r_sck;
          r_edge <= r_edge + EW'(1);
        end
        if (w_shift)
          r_tx <= LSB_FIRST ? (r_tx >> 1) : (r_tx << 1);
        if (w_sample)
          r_rx <= LSB_FIRST ? {w_sin, r_rx[WIDTH-1:1]} : {r_rx[WIDTH-2:0], w_sin};
        if (r_state == TRAIL && w_hp_end) begin
          r_done    <= 1'b1;
          r_rx_data <= r_rx;
        end
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx_data;
  assign bus.sck     = r_sck;
  assign bus.cs_n    = w_cs_n;
  assign bus.mosi    = w_mosi;
endmodule
